// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequential multiplier state encoding and step-count helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // Number of CALC cycles needed to retire all multiplier bits.
    function automatic int unsigned mul_steps(input int unsigned width, input int unsigned bpc);
        return (width + 1) / bpc;
    endfunction

endpackage

// File: rtl/mul_pp_step.sv
// Combinational BPC-bit partial-product generator in shift-add form.
module mul_pp_step #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned BPC   = 2,
    parameter int unsigned SW    = 2
) (
    input  logic [WIDTH:0]             mcand,
    input  logic [BPC-1:0]             bits,
    input  logic [SW-1:0]              shift,
    output logic [2*(WIDTH+1)-1:0]     addend_c
);

    localparam int unsigned PW = 2 * (WIDTH + 1);

    logic [PW-1:0] sum;

    // Sum of shifted multiplicand copies, then placed at the current digit position.
    always_comb begin
        sum = '0;
        for (int i = 0; i < BPC; i++) begin
            if (bits[i]) begin
                sum = sum + (PW'(mcand) << i);
            end
        end
        addend_c = sum << (32'(shift) * BPC);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier with valid/ready handshake, BPC bits per cycle.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned BPC   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       is_signed,
    input  logic [WIDTH:0]             a,
    input  logic [WIDTH:0]             b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*(WIDTH+1)-1:0]     product,
    output logic [WIDTH:0]             out,
    output logic                       ovf
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned PW = 2 * W1;
    localparam int unsigned N  = mul_steps(WIDTH, BPC);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || ((W1 % BPC) != 0)) begin : g_bad_cfg
        $error("seq_multiplier: BPC must be 1, 2 or 4 and divide WIDTH+1");
    end

    mul_state_t     state;
    mul_state_t     next_state;
    logic [WIDTH:0] mcand;
    logic [WIDTH:0] mplier;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  addend;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           sgn;
    logic           accept;
    logic           last_step;
    logic [WIDTH:0] a_mag;
    logic [WIDTH:0] b_mag;
    logic [PW-1:0]  fix_product;
    logic           fix_ovf;

    // Ready is held low while in reset and during a flush cycle.
    assign in_ready  = rst_n & ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign last_step = (cnt == CW'(N - 1));
    assign out_valid = (state == DONE);
    assign out       = product[WIDTH:0];

    assign a_mag = (is_signed & a[WIDTH]) ? (~a + W1'(1)) : a;
    assign b_mag = (is_signed & b[WIDTH]) ? (~b + W1'(1)) : b;

    assign fix_product = neg ? (~acc + PW'(1)) : acc;
    assign fix_ovf     = sgn ? (fix_product[PW-1:W1] != {W1{fix_product[WIDTH]}})
                             : (fix_product[PW-1:W1] != '0);

    mul_pp_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .SW    (CW)
    ) u_pp (
        .mcand    (mcand),
        .bits     (mplier[BPC-1:0]),
        .shift    (cnt),
        .addend_c (addend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over everything; DONE either chains a new op or drains to IDLE.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = CALC;
                CALC:    if (last_step) next_state = FIX;
                FIX:     next_state = DONE;
                DONE: begin
                    if (accept) begin
                        next_state = CALC;
                    end else if (out_ready) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sgn     <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            if (accept) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                neg    <= is_signed & (a[WIDTH] ^ b[WIDTH]);
                sgn    <= is_signed;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= acc + addend;
                mplier <= mplier >> BPC;
                cnt    <= cnt + CW'(1);
            end
            // Visible result only moves when FIX completes un-flushed.
            if ((state == FIX) && !flush) begin
                product <= fix_product;
                ovf     <= fix_ovf;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=7, BPC=2): directed vectors, backpressure, reset, flush, random.
module tb_seq_multiplier;

    typedef struct {
        logic [15:0] p;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [7:0]  out;
    logic        ovf;

    logic        rnd_ready = 1'b0;
    logic        rnd_bit = 1'b1;
    logic        ready_req = 1'b1;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    assign out_ready = rnd_ready ? rnd_bit : ready_req;

    seq_multiplier #(.WIDTH(7), .BPC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out       (out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got product=0x%0h, required no result", product);
            end else begin
                if (product !== q[0].p || out !== q[0].p[7:0] || ovf !== q[0].ovf) begin
                    n_fail++;
                    $display("FAIL result: got product=0x%0h out=0x%0h ovf=%0b, required product=0x%0h out=0x%0h ovf=%0b",
                             product, out, ovf, q[0].p, q[0].p[7:0], q[0].ovf);
                end
                if (out_ready) q.delete(0);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic s,
                         input logic [15:0] ep, input logic eo);
        bit done = 0;
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        is_signed = s;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (in_ready) begin
                q.push_back('{p: ep, ovf: eo});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready=0 for 200 cycles, required acceptance");
        end
    endtask

    // Latency counted with the accept cycle as cycle 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    function automatic exp_t model(input logic [7:0] va, input logic [7:0] vb, input logic s);
        int   pr;
        exp_t e;
        if (s) begin
            pr    = int'($signed(va)) * int'($signed(vb));
            e.ovf = (pr < -128) || (pr > 127);
        end else begin
            pr    = int'(va) * int'(vb);
            e.ovf = (pr > 255);
        end
        e.p = pr[15:0];
        return e;
    endfunction

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        s;
        logic [15:0] p;
        logic        o;
    } vec_t;

    vec_t vecs[9] = '{
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1},
        '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0},
        '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1},
        '{8'h00, 8'h5A, 1'b1, 16'h0000, 1'b0},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0},
        '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0},
        '{8'h10, 8'h10, 1'b0, 16'h0100, 1'b1},
        '{8'h0F, 8'h11, 1'b0, 16'h00FF, 1'b0}
    };

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;

        // Directed vectors, each with latency check.
        foreach (vecs[i]) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].s, vecs[i].p, vecs[i].o);
            wait_valid(lat);
            check($sformatf("latency_vec%0d", i), 32'(lat), 32'd6);
        end
        @(posedge clk);
        #1;
        check("valid_drop", 32'(out_valid), 32'd0);

        // Backpressure then same-cycle back-to-back accept.
        ready_req = 1'b0;
        issue(8'h0B, 8'h0D, 1'b0, 16'h008F, 1'b0);
        wait_valid(lat);
        check("latency_bp", 32'(lat), 32'd6);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        ready_req = 1'b1;
        issue(8'h03, 8'h04, 1'b0, 16'h000C, 1'b0);
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        wait_valid(lat);
        check("latency_b2b", 32'(lat), 32'd6);
        @(posedge clk);
        #1;

        // Reset in the second CALC cycle.
        issue(8'h05, 8'h09, 1'b0, 16'h002D, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(8'h07, 8'h06, 1'b0, 16'h002A, 1'b0);
        wait_valid(lat);
        check("latency_after_rst", 32'(lat), 32'd6);
        @(posedge clk);
        #1;

        // Flush in the third CALC cycle.
        issue(8'h09, 8'h09, 1'b0, 16'h0051, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        check("flush_calc_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        q.delete();
        #1;
        check("flush_calc_valid", 32'(out_valid), 32'd0);
        check("flush_calc_idle", 32'(in_ready), 32'd1);
        check("flush_calc_hold", 32'(product), 32'h002A);
        repeat (8) @(posedge clk);
        #1;
        issue(8'h02, 8'h03, 1'b0, 16'h0006, 1'b0);
        wait_valid(lat);
        check("latency_after_flush", 32'(lat), 32'd6);
        @(posedge clk);
        #1;

        // Flush while a result is held in DONE.
        ready_req = 1'b0;
        issue(8'h0C, 8'h0C, 1'b0, 16'h0090, 1'b0);
        wait_valid(lat);
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_done_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        q.delete();
        ready_req = 1'b1;
        #1;
        check("flush_done_valid", 32'(out_valid), 32'd0);
        check("flush_done_hold", 32'(product), 32'h0090);
        repeat (4) @(posedge clk);
        #1;
        issue(8'hFE, 8'h03, 1'b1, 16'hFFFA, 1'b0);
        wait_valid(lat);
        check("latency_after_flush_done", 32'(lat), 32'd6);
        @(posedge clk);
        #1;

        // Random operations with random gaps and consumer stalls.
        rnd_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            e  = model(ra, rb, rs);
            issue(ra, rb, rs, e.p, e.ovf);
        end
        for (int k = 0; k < 400 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        rnd_ready = 1'b0;
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
